// File: rtl/somador_sequencial_pkg.sv
// ============================================================================
// Module : calc_pkg
// Brief  : Shared opcode and FSM encodings for the calculator datapath, plus
//          a helper that sizes the chunk counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width able to hold 0..k-1, never narrower than one bit.
  function automatic int cnt_width(input int k);
    return (k <= 1) ? 1 : $clog2(k);
  endfunction

endpackage

`default_nettype wire

// File: rtl/somador_sequencial_if.sv
// ============================================================================
// Module : somador_sequencial_if
// Brief  : Start/done request bus between operand registers (master) and the
//          sequential adder (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface somador_sequencial_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, A, B, cin,
    input  busy, done, S, cout, ovf, zero
  );

  modport slave (
    input  start, op, A, B, cin,
    output busy, done, S, cout, ovf, zero
  );

endinterface

`default_nettype wire

// File: rtl/somador_bloco.sv
// ============================================================================
// Module : somador_bloco
// Brief  : CHUNK-bit ripple adder built from somador_completo cells. Also
//          exposes the carry into its top bit so the caller can form the
//          signed overflow flag when this block holds the operand MSB.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module somador_bloco #(
  parameter int CHUNK = 2
) (
  input  wire logic [CHUNK-1:0] a,
  input  wire logic [CHUNK-1:0] b,
  input  wire logic             cin,
  output logic      [CHUNK-1:0] s,
  output logic                  cout,
  output logic                  c_msb_in
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    somador_completo u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .s    (s[i]),
      .cout (w_c[i+1])
    );
  end

  assign cout     = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/somador_completo.sv
// ============================================================================
// Module : somador_completo
// Brief  : One-bit full adder cell.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module somador_completo (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      s,
  output logic      cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/somador_sequencial.sv
// ============================================================================
// Module : somador_sequencial
// Brief  : Multi-cycle adder/subtractor. Adds CHUNK bits per cycle, LSB chunk
//          first, carrying between cycles in a register. Subtraction is done
//          as A + ~B + ~borrow_in. Reports carry, signed overflow and zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module somador_sequencial
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input wire logic            clk,
  input wire logic            rst,
  somador_sequencial_if.slave bus
);

  localparam int K  = WIDTH / CHUNK;
  localparam int CW = cnt_width(K);

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("somador_sequencial: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  if ($bits(bus.A) != WIDTH) begin : g_bad_bus
    $error("somador_sequencial: bus WIDTH does not match WIDTH");
  end

  state_t           r_state;
  logic [CW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_s;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_s_next;
  logic             w_last;

  // Operands are shifted right each cycle, so the active chunk is always
  // at the bottom of the shift registers.
  somador_bloco #(.CHUNK(CHUNK)) u_bloco (
    .a        (r_a[CHUNK-1:0]),
    .b        (r_b[CHUNK-1:0]),
    .cin      (r_c),
    .s        (w_sum),
    .cout     (w_cout),
    .c_msb_in (w_cmsb)
  );

  assign w_last = (r_idx == CW'(K - 1));

  // Result with the current chunk merged in; on the last chunk this is the
  // final sum, which is what the zero flag must look at.
  always_comb begin
    w_s_next = r_s;
    w_s_next[int'(r_idx)*CHUNK +: CHUNK] = w_sum;
  end

  // Control FSM, operand/carry registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_s     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= (bus.op == OP_SUB) ? ~bus.B : bus.B;
            r_c     <= (bus.op == OP_SUB) ? ~bus.cin : bus.cin;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_s <= w_s_next;
          r_c <= w_cout;
          r_a <= r_a >> CHUNK;
          r_b <= r_b >> CHUNK;
          if (w_last) begin
            r_cout  <= w_cout;
            r_ovf   <= w_cout ^ w_cmsb;
            r_zero  <= ~|w_s_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.S    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;

endmodule

`default_nettype wire
